// File: rtl/serial_sched_pkg.sv
// Shared types and helpers for the serial transmit scheduler.
package serial_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // $clog2 that never returns 0, so a 1-value counter still gets one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above 'last', wrapping.
module rr_arbiter
   import serial_sched_pkg::*;
#(
   parameter int n = 4
) (
   input  logic [n-1:0]               req,
   input  logic [clog2_min1(n)-1:0]   last,
   output logic [n-1:0]               grant,
   output logic [clog2_min1(n)-1:0]   grant_idx,
   output logic                       any
);

   localparam int LW = clog2_min1(n);

   logic [LW-1:0] idx;

   // Walk last+1 .. last+n (mod n) and keep the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 1; k <= n; k++) begin
         idx = LW'((int'(last) + k) % n);
         if (!any && req[idx]) begin
            any       = 1'b1;
            grant_idx = idx;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_tx_scheduler.sv
// One shared LSB-first shifter fed by a round-robin pick of n_ch requesters.
module serial_tx_scheduler
   import serial_sched_pkg::*;
#(
   parameter int n_ch  = 4,
   parameter int width = 8,
   parameter int gap   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [n_ch-1:0]               req_valid,
   input  logic [n_ch*width-1:0]         req_data,
   output logic [n_ch-1:0]               req_ready,
   output logic                          busy,
   output logic                          serial_valid,
   output logic                          serial_data,
   output logic [clog2_min1(n_ch)-1:0]   serial_ch,
   output logic                          serial_last
);

   localparam int CW = clog2_min1(n_ch);
   localparam int IW = clog2_min1(width);
   localparam int GW = clog2_min1(gap + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(width - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((gap > 0) ? gap - 1 : 0);

   state_t           state, state_nxt;
   logic [IW-1:0]    bit_idx;
   logic [GW-1:0]    gap_cnt;
   logic [CW-1:0]    last_ch, cur_ch, grant_idx;
   logic [width-1:0] word, acc_word;
   logic [n_ch-1:0]  grant;
   logic             any, accept;

   rr_arbiter #(.n(n_ch)) u_arb (
      .req       (req_valid),
      .last      (last_ch),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   // Reset gates ready directly so nothing is accepted while rst is low.
   assign accept    = any && (state == IDLE) && rst;
   assign req_ready = accept ? grant : '0;
   assign acc_word  = req_data[grant_idx*width +: width];
   assign busy      = (state != IDLE);

   // State, captured frame and counters; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         gap_cnt <= '0;
         last_ch <= CW'(n_ch - 1);
         cur_ch  <= '0;
         word    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            word    <= acc_word;
            cur_ch  <= grant_idx;
            last_ch <= grant_idx;
            bit_idx <= (width > 1) ? IW'(1) : '0;
         end else if (state == SHIFT) begin
            bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
         end
         if (state == GAP)
            gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
      end
   end

   // Next state and serial output mux; bit 0 leaves in the accept cycle.
   always_comb begin
      state_nxt    = state;
      serial_valid = 1'b0;
      serial_data  = 1'b0;
      serial_last  = 1'b0;
      serial_ch    = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               serial_valid = 1'b1;
               serial_data  = acc_word[0];
               serial_ch    = grant_idx;
               serial_last  = (width == 1);
               if (width > 1)    state_nxt = SHIFT;
               else if (gap > 0) state_nxt = GAP;
               else              state_nxt = IDLE;
            end
         end
         SHIFT: begin
            serial_valid = 1'b1;
            serial_data  = word[bit_idx];
            serial_ch    = cur_ch;
            serial_last  = (bit_idx == IDX_LAST);
            if (bit_idx == IDX_LAST)
               state_nxt = (gap > 0) ? GAP : IDLE;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench: four scheduler instances covering gap=1, gap=0, gap=3 and width=1.
module tb_serial_tx_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // u_g1: width 8, gap 1
   logic [3:0]  v1, rr1;
   logic [31:0] d1;
   logic        b1, sv1, sd1, sl1;
   logic [1:0]  sc1;
   // u_g0: width 8, gap 0
   logic [3:0]  v0, rr0;
   logic [31:0] d0;
   logic        b0, sv0, sd0, sl0;
   logic [1:0]  sc0;
   // u_g3: width 8, gap 3
   logic [3:0]  v3, rr3;
   logic [31:0] d3;
   logic        b3, sv3, sd3, sl3;
   logic [1:0]  sc3;
   // u_w1: width 1, gap 0
   logic [3:0]  vw, rrw, dw;
   logic        bw, svw, sdw, slw;
   logic [1:0]  scw;

   // Packed view: {valid, data, last, ch[1:0], busy, ready[3:0]}
   logic [9:0] o1, o0, o3, ow;
   assign o1 = {sv1, sd1, sl1, sc1, b1, rr1};
   assign o0 = {sv0, sd0, sl0, sc0, b0, rr0};
   assign o3 = {sv3, sd3, sl3, sc3, b3, rr3};
   assign ow = {svw, sdw, slw, scw, bw, rrw};

   serial_tx_scheduler #(.n_ch(4), .width(8), .gap(1)) u_g1 (
      .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1), .req_ready(rr1), .busy(b1),
      .serial_valid(sv1), .serial_data(sd1), .serial_ch(sc1), .serial_last(sl1));
   serial_tx_scheduler #(.n_ch(4), .width(8), .gap(0)) u_g0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0), .req_ready(rr0), .busy(b0),
      .serial_valid(sv0), .serial_data(sd0), .serial_ch(sc0), .serial_last(sl0));
   serial_tx_scheduler #(.n_ch(4), .width(8), .gap(3)) u_g3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rr3), .busy(b3),
      .serial_valid(sv3), .serial_data(sd3), .serial_ch(sc3), .serial_last(sl3));
   serial_tx_scheduler #(.n_ch(4), .width(1), .gap(0)) u_w1 (
      .clk(clk), .rst(rst), .req_valid(vw), .req_data(dw), .req_ready(rrw), .busy(bw),
      .serial_valid(svw), .serial_data(sdw), .serial_ch(scw), .serial_last(slw));

   task automatic test_reset;
      rst = 1'b0;
      v1 = 4'hF; d1 = 32'hFFFF_FFFF;
      v0 = '0; d0 = '0; v3 = '0; d3 = '0; vw = 4'hF; dw = 4'hF;
      @(negedge clk);
      checks++;
      if (o1 !== 10'h0) begin failures++; $display("FAIL reset_g1 got=%b exp=%b", o1, 10'h0); end
      checks++;
      if (ow !== 10'h0) begin failures++; $display("FAIL reset_w1 got=%b exp=%b", ow, 10'h0); end
      checks++;
      if (o0 !== 10'h0) begin failures++; $display("FAIL reset_g0 got=%b exp=%b", o0, 10'h0); end
      v1 = '0; vw = '0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_single;
      logic [7:0] w;
      logic [9:0] exp;
      w  = 8'hA5;
      d1 = 32'h00A5_0000;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         v1 = (c == 0) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (c == 0)      exp = {1'b1, w[0], 1'b0, 2'd2, 1'b0, 4'b0100};
         else if (c < 8)  exp = {1'b1, w[c], (c == 7), 2'd2, 1'b1, 4'b0000};
         else if (c == 8) exp = {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
         else             exp = 10'h0;
         checks++;
         if (o1 !== exp) begin failures++; $display("FAIL single c=%0d got=%b exp=%b", c, o1, exp); end
      end
   endtask

   task automatic test_fairness;
      logic [7:0] fw [4];
      logic [9:0] exp;
      int f, b, ch;
      fw[0] = 8'h3C; fw[1] = 8'hC3; fw[2] = 8'h5A; fw[3] = 8'h96;
      d0 = {fw[3], fw[2], fw[1], fw[0]};
      for (int c = 0; c < 49; c++) begin
         @(posedge clk); #1;
         v0 = (c < 48) ? 4'hF : 4'h0;
         @(negedge clk);
         f = c / 8; b = c % 8; ch = f % 4;
         if (c < 48)
            exp = {1'b1, fw[ch][b], (b == 7), 2'(ch), (b != 0),
                   (b == 0) ? 4'(1 << ch) : 4'b0000};
         else
            exp = 10'h0;
         checks++;
         if (o0 !== exp) begin failures++; $display("FAIL fairness c=%0d got=%b exp=%b", c, o0, exp); end
      end
   endtask

   task automatic test_gap;
      logic [7:0] w;
      logic [9:0] exp;
      int b;
      w  = 8'h81;
      d3 = 32'h0000_8100;
      for (int c = 0; c < 23; c++) begin
         @(posedge clk); #1;
         v3 = (c <= 11) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         if (c < 8 || (c >= 11 && c < 19)) begin
            b   = (c < 8) ? c : c - 11;
            exp = {1'b1, w[b], (b == 7), 2'd1, (b != 0), (b == 0) ? 4'b0010 : 4'b0000};
         end else if (c < 22) begin
            exp = {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
         end else begin
            exp = 10'h0;
         end
         checks++;
         if (o3 !== exp) begin failures++; $display("FAIL gap c=%0d got=%b exp=%b", c, o3, exp); end
      end
   endtask

   // Leaves ch3's frame at bit 3, sampled, for the reset test that follows.
   task automatic test_midframe;
      logic [7:0] wa, wb;
      logic [9:0] exp;
      int b;
      wa = 8'h3C; wb = 8'h96;
      d1 = {wb, 16'h0000, wa};
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         v1 = {(c >= 4 && c <= 9), 2'b00, (c == 0)};
         @(negedge clk);
         if (c < 8) begin
            exp = {1'b1, wa[c], (c == 7), 2'd0, (c != 0), (c == 0) ? 4'b0001 : 4'b0000};
         end else if (c == 8) begin
            exp = {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
         end else begin
            b   = c - 9;
            exp = {1'b1, wb[b], 1'b0, 2'd3, (b != 0), (b == 0) ? 4'b1000 : 4'b0000};
         end
         checks++;
         if (o1 !== exp) begin failures++; $display("FAIL midframe c=%0d got=%b exp=%b", c, o1, exp); end
      end
   endtask

   task automatic test_reset_midframe;
      logic [9:0] exp;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (o1 !== 10'h0) begin failures++; $display("FAIL rst_async got=%b exp=%b", o1, 10'h0); end
      v1 = 4'b0110;
      d1 = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (o1 !== 10'h0) begin failures++; $display("FAIL rst_held got=%b exp=%b", o1, 10'h0); end
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         if (c == 0) rst = 1'b1;
         v1 = (c == 0) ? 4'b0110 : (c <= 9) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (c == 0)      exp = {1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0010};
         else if (c < 8)  exp = {1'b1, 1'b0, (c == 7), 2'd1, 1'b1, 4'b0000};
         else if (c == 8) exp = {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
         else if (c == 9) exp = {1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0100};
         else if (c == 18) exp = 10'h0;
         else continue;
         checks++;
         if (o1 !== exp) begin failures++; $display("FAIL rst_release c=%0d got=%b exp=%b", c, o1, exp); end
      end
   endtask

   task automatic test_width1;
      logic [9:0] exp;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         case (c)
            0:       begin vw = 4'b0001; dw = 4'b0001; end
            1:       begin vw = 4'b0010; dw = 4'b0000; end
            3:       begin vw = 4'b1111; dw = 4'b1111; end
            default: begin vw = 4'b0000; dw = 4'b0000; end
         endcase
         @(negedge clk);
         case (c)
            0:       exp = {1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
            1:       exp = {1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010};
            3:       exp = {1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100};
            default: exp = 10'h0;
         endcase
         checks++;
         if (ow !== exp) begin failures++; $display("FAIL width1 c=%0d got=%b exp=%b", c, ow, exp); end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_fairness;
      test_gap;
      test_midframe;
      test_reset_midframe;
      test_width1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Shares one serial output line among `n_ch` parallel requesters. Each requester offers a `width`-bit word with a valid/ready handshake. A round-robin arbiter picks one, and the block shifts that word out LSB-first on a single serial line, tagged with the channel number. Optional idle gap cycles separate frames. It sits in front of a serial link and replaces per-channel serializers with one scheduled shifter.

## Interface
- `n_ch`, 4, number of requesters; at least 2
- `width`, 8, bits per word; at least 1
- `gap`, 1, idle cycles inserted after each frame; 0 allowed
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low: asserted when 0, released when 1
- `req_valid`  in  n_ch  per-channel word available
- `req_data`  in  n_ch*width  flattened words; channel i occupies bits [i*width +: width]
- `req_ready`  out  n_ch  one-hot or zero; channel i word accepted this cycle
- `busy`  out  1  frame in progress or gap pending; no new accept possible
- `serial_valid`  out  1  `serial_data` is a valid bit
- `serial_data`  out  1  current bit, LSB first
- `serial_ch`  out  $clog2(n_ch)  channel owning the current bit
- `serial_last`  out  1  current bit is bit `width-1` of the frame

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - The arbiter grants the first requesting channel, searching upward from `last_ch+1` modulo `n_ch`.
  - `req_ready[grant]` = 1 combinationally.
  - Accept means `req_valid[i] & req_ready[i]`.
  - In the accept cycle, drive `serial_data` = `req_data[i][0]`, `serial_valid` = 1, `serial_ch` = i.
  - On accept, capture the word and set `last_ch` = i.
  - Next state: SHIFT if `width` > 1; else GAP if `gap` > 0; else IDLE.
- **SHIFT**
  - `serial_data` = captured word bit at the bit index; the index runs 1 to `width-1`.
  - `serial_valid` = 1.
  - `serial_ch` holds the captured channel.
  - Leave after bit `width-1`: to GAP if `gap` > 0, else to IDLE.
- **GAP**
  - Count `gap` cycles with `serial_valid` = 0, then return to IDLE.
- Output defaults outside the cases above: `serial_valid` = 0, `serial_data` = 0, `serial_last` = 0, `serial_ch` = 0.
- `busy` = (state != IDLE).
- `req_ready` is all zero whenever state != IDLE or `rst` = 0.
- Requesters must hold `req_valid` and `req_data` until accepted. Deasserting `req_valid` without an accept drops the request with no side effect.
- Fairness: while all channels request, grants rotate 0,1,...,n_ch-1,0,...

## Timing
- Latency from accept to first bit: 0 cycles; bit 0 appears in the accept cycle.
- Frame length: `width` cycles of `serial_valid`. `serial_last` is high only on the final bit, which is the accept cycle when `width` = 1.
- Spacing with `gap` = 0: the next accept happens in the cycle after the last bit, so back-to-back frames stream with no bubble.
- Spacing with `gap` = g: exactly g cycles with `serial_valid` low between frames.
- Reset state: state = IDLE, bit index = 0, gap counter = 0, `last_ch` = `n_ch-1` (so channel 0 wins first), captured word = 0, all outputs 0.
- Reset mid-frame: the frame is aborted at once, with no partial completion. The first accept after release of `rst` is the lowest requesting channel, searching from 0.
- A new request arriving mid-frame waits; it is never lost or reordered relative to round-robin.
- A request from the channel currently being shifted is eligible again in the next IDLE, subject to rotation.
- Counter widths: bit index is $clog2(width) bits (minimum 1). Gap counter is $clog2(gap+1) bits (minimum 1).

## Structure
- Shared package `serial_sched_pkg`: FSM state enum (IDLE, SHIFT, GAP) and a helper function for the minimum-1 `$clog2` width.
- Sub-module `rr_arbiter` (parameter `n`):
  - inputs: `req[n]`, `last[$clog2(n)]`
  - outputs: one-hot `grant[n]`, encoded `grant_idx`, `any`
  - purely combinational; `last_ch` is held in the parent.
- The parent holds the FSM, captured word, bit index, gap counter and output muxing.

## Test plan
- Single request, `n_ch`=4, `width`=8, `gap`=1: ch2 offers 0xA5 → `req_ready[2]` is high in the same cycle. `serial_data` = 1,0,1,0,0,1,0,1 with `serial_ch` = 2, `serial_last` on the 8th bit, `busy` high for 8 cycles, then 1 idle cycle.
- Fairness: all 4 channels request continuously with `gap`=0 → grant order 0,1,2,3,0,1. Frames are contiguous and `serial_valid` never drops.
- Gap: `gap`=3, two back-to-back requests on ch1 → exactly 3 cycles of `serial_valid` = 0 between frames.
- Mid-frame arrival: ch3 requests during ch0's bit 4 → ch3 is accepted in the first IDLE cycle after ch0's last bit (or after the gap), and ch0's frame is unaffected.
- Reset mid-frame: `rst` driven 0 during bit 3 → all outputs are 0 immediately and asynchronously. After release with ch1 and ch2 requesting, ch1 is granted first.
- `width`=1: ch0 offers 1 → one-cycle frame with `serial_valid`, `serial_data` and `serial_last` all 1 in the accept cycle.
